// File: rtl/temporal_encoder.sv
`default_nettype none
// ============================================================================
// Module   : temporal_encoder
// Purpose  : Race-logic temporal encoder. Accepts binary values over a
//            valid/ready handshake, double-buffers them, and emits one value
//            per gamma cycle as an event on edge_out. The event time, counted
//            in aclk cycles from set_out, equals the value. A null value
//            produces no event.
// Ports    : aclk      - clock, rising-edge active
//            grst      - synchronous active-high reset
//            in_valid  - in_value / in_null presented
//            in_value  - event time, 0..GAMMA_CYCLE_WIDTH-1
//            in_null   - encode "no event"; in_value ignored
//            in_ready  - a value can be accepted this cycle
//            set_out   - high on the first aclk cycle of each gamma cycle
//            edge_out  - temporal event output
//            gamma_cnt - position within the current gamma cycle
// Config   : TE_PULSE_MODE_EN - when defined, edge_out is a pulse of
//            PULSE_WIDTH cycles (truncated at the gamma boundary) instead of
//            a level held until the end of the gamma cycle.
// Revision : 1.0 - initial release
// ============================================================================
module temporal_encoder #(
    parameter int GAMMA_CYCLE_WIDTH = 16,
    parameter int PULSE_WIDTH       = 8,
    parameter int VALUE_WIDTH       = $clog2(GAMMA_CYCLE_WIDTH)
) (
    input  logic                   aclk,
    input  logic                   grst,
    input  logic                   in_valid,
    input  logic [VALUE_WIDTH-1:0] in_value,
    input  logic                   in_null,
    output logic                   in_ready,
    output logic                   set_out,
    output logic                   edge_out,
    output logic [VALUE_WIDTH-1:0] gamma_cnt
);

    // GAMMA_CYCLE_WIDTH <= 2**VALUE_WIDTH, so it always fits in one extra bit.
    localparam logic [VALUE_WIDTH:0]   c_GAMMA      = (VALUE_WIDTH+1)'(GAMMA_CYCLE_WIDTH);
    localparam logic [VALUE_WIDTH-1:0] c_GAMMA_LAST = VALUE_WIDTH'(GAMMA_CYCLE_WIDTH - 1);
    localparam logic [VALUE_WIDTH-1:0] c_CNT_ONE    = VALUE_WIDTH'(1);

    logic [VALUE_WIDTH-1:0] cnt_q,      cnt_d;
    logic [VALUE_WIDTH-1:0] act_val_q,  act_val_d;
    logic                   act_null_q, act_null_d;
    logic [VALUE_WIDTH-1:0] hold_val_q, hold_val_d;
    logic                   hold_null_q, hold_null_d;
    logic                   hold_full_q, hold_full_d;

    logic w_last;
    logic w_xfer;
    logic w_in_is_null;
    logic w_edge;

    assign w_last       = (cnt_q == c_GAMMA_LAST);
    assign w_xfer       = in_valid && !hold_full_q;
    // Out-of-range values (non-power-of-2 gamma only) encode as infinity.
    assign w_in_is_null = in_null || ({1'b0, in_value} >= c_GAMMA);

    always_comb begin
        cnt_d       = w_last ? '0 : (cnt_q + c_CNT_ONE);
        act_val_d   = act_val_q;
        act_null_d  = act_null_q;
        hold_val_d  = hold_val_q;
        hold_null_d = hold_null_q;
        hold_full_d = hold_full_q;

        // Transfers before the last cycle park in the holding register.
        if (w_xfer && !w_last) begin
            hold_val_d  = in_value;
            hold_null_d = w_in_is_null;
            hold_full_d = 1'b1;
        end

        // Gamma boundary: promote the next value into the active register.
        // A last-cycle transfer can only happen with the holding register
        // empty (in_ready is low otherwise), so it bypasses straight in.
        if (w_last) begin
            if (hold_full_q) begin
                act_val_d   = hold_val_q;
                act_null_d  = hold_null_q;
                hold_full_d = 1'b0;
            end else if (w_xfer) begin
                act_val_d  = in_value;
                act_null_d = w_in_is_null;
            end else begin
                act_val_d  = '0;
                act_null_d = 1'b1;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (grst) begin
            cnt_q       <= '0;
            act_val_q   <= '0;
            act_null_q  <= 1'b1;
            hold_val_q  <= '0;
            hold_null_q <= 1'b1;
            hold_full_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            act_val_q   <= act_val_d;
            act_null_q  <= act_null_d;
            hold_val_q  <= hold_val_d;
            hold_null_q <= hold_null_d;
            hold_full_q <= hold_full_d;
        end
    end

`ifdef TE_PULSE_MODE_EN
    // A pulse longer than the gamma cycle behaves like one exactly that long;
    // saturating keeps act_val + width inside VALUE_WIDTH+1 bits.
    localparam logic [VALUE_WIDTH:0] c_PW = (VALUE_WIDTH+1)'(
        (PULSE_WIDTH > GAMMA_CYCLE_WIDTH) ? GAMMA_CYCLE_WIDTH : PULSE_WIDTH);

    // The counter wraps at the boundary, so the pulse is cut off there.
    assign w_edge = !act_null_q
                 && (cnt_q >= act_val_q)
                 && ({1'b0, cnt_q} < ({1'b0, act_val_q} + c_PW));
`else
    logic w_unused_pw;
    assign w_unused_pw = (PULSE_WIDTH > 0);

    // Level code: at cnt_q == 0 this is only true when act_val_q == 0.
    assign w_edge = !act_null_q && (cnt_q >= act_val_q);
`endif

    assign in_ready  = !hold_full_q;
    assign set_out   = (cnt_q == '0);
    assign edge_out  = w_edge;
    assign gamma_cnt = cnt_q;

endmodule
`default_nettype wire

// File: doc/temporal_encoder.md
# temporal_encoder

Converts binary values into race-logic temporal events for the spatio-temporal compute fabric. It sits directly upstream of the comparison gates and feeds them two things:
- a `set_out` pulse that opens every gamma cycle;
- an `edge_out` event whose arrival time, counted in aclk cycles from the start of the gamma cycle, equals the encoded value.

Values arrive over a valid/ready handshake, are double-buffered, and are emitted one per gamma cycle. An empty slot is emitted as "null" (no event).

## Interface
- `GAMMA_CYCLE_WIDTH`, 16: aclk cycles per gamma cycle; must be ≥ 2.
- `PULSE_WIDTH`, 8: event pulse length in aclk cycles; used only when `TE_PULSE_MODE_EN` is defined; must be ≥ 1.
- `VALUE_WIDTH`, `$clog2(GAMMA_CYCLE_WIDTH)`: derived; do not override.

Ports (one clock; reset is synchronous and active-high):
- `aclk`  in  1  clock; all state updates on the rising edge.
- `grst`  in  1  synchronous active-high reset.
- `in_valid`  in  1  `in_value`/`in_null` are presented.
- `in_value`  in  `VALUE_WIDTH`  event time, 0..`GAMMA_CYCLE_WIDTH`-1.
- `in_null`  in  1  encode "no event" (infinity); `in_value` is ignored.
- `in_ready`  out  1  a value can be accepted this cycle.
- `set_out`  out  1  high for the first aclk cycle of each gamma cycle; drives downstream `set`.
- `edge_out`  out  1  temporal event output.
- `gamma_cnt`  out  `VALUE_WIDTH`  current position within the gamma cycle (status).

## Operation
- **Gamma counter**
  - Free-running, 0..`GAMMA_CYCLE_WIDTH`-1, wrapping to 0.
  - `set_out` = (`gamma_cnt` == 0).
- **Storage**
  - Active register (`act_val`, `act_null`): the value being emitted this gamma cycle.
  - One-entry holding register (`hold_val`, `hold_null`, `hold_full`).
- **Handshake**
  - `in_ready` = !`hold_full`.
  - Transfer occurs when `in_valid` && `in_ready`.
  - `in_value` ≥ `GAMMA_CYCLE_WIDTH` (only possible for non-power-of-2 gamma) is treated as null.
- **Capture**
  - A transfer with `gamma_cnt` < `GAMMA_CYCLE_WIDTH`-1 writes the holding register.
  - A transfer with `gamma_cnt` == `GAMMA_CYCLE_WIDTH`-1 while the holding register is empty bypasses it and loads the active register directly for the next gamma cycle.
- **Boundary** (`gamma_cnt` == `GAMMA_CYCLE_WIDTH`-1 → 0)
  - Holding full: move holding → active and clear `hold_full`.
  - Bypass transfer: load it into active.
  - Otherwise: active becomes null.
  - A value is emitted in exactly one gamma cycle, never repeated.
- **Edge mode (default)**
  - `edge_out` = !`act_null` && (`gamma_cnt` ≥ `act_val`).
  - It is a rising-edge code that holds until the end of the gamma cycle.
  - It is forced low in the cycle `gamma_cnt` == 0 unless `act_val` == 0.
- **Null**: `edge_out` stays 0 for the whole gamma cycle.
- **Reset**
  - `grst` sampled high clears the counter, holding register and active register (active = null) regardless of state, including mid-gamma-cycle.
  - In-flight data is discarded.

## Timing
- All outputs are registered or decoded only from registers; there is no combinational path from inputs to outputs.
- Output values while `grst` is sampled high and in the cycle after:
  - `gamma_cnt` = 0, `set_out` = 1;
  - `edge_out` = 0;
  - `in_ready` = 1.
- The first gamma cycle after reset always emits null.
- Latency: a value accepted in gamma cycle k is emitted in gamma cycle k+1.
  - `edge_out` rises in the aclk cycle where `gamma_cnt` == value, i.e. value cycles after `set_out`.
- Throughput: one value per gamma cycle.
  - `in_ready` deasserts after a hold capture.
  - `in_ready` reasserts in the cycle `gamma_cnt` == 0 of the next gamma cycle.
- Simultaneous last-cycle transfer and full holding register cannot occur, because `in_ready` = 0 then.
- `in_valid` may drop without a transfer; no state changes.

## Configuration
- **`TE_PULSE_MODE_EN` defined** (pulse-width encoding, for pulse-based downstream gates):
  - `edge_out` = !`act_null` && (`gamma_cnt` ≥ `act_val`) && (`gamma_cnt` < `act_val` + `PULSE_WIDTH`).
  - The comparison is done at `VALUE_WIDTH`+1 bits to avoid wrap.
  - The pulse is truncated at the gamma boundary and never spills into the next gamma cycle.
- **Undefined**: edge (level) mode as in Operation; `PULSE_WIDTH` is unused.

## Test plan
- **Reset then idle**, `GAMMA_CYCLE_WIDTH`=16:
  - `set_out` pulses every 16 cycles starting the cycle after `grst` falls;
  - `edge_out` stays 0;
  - `in_ready` stays 1.
- **Single value**: accept 5 at `gamma_cnt`=3 → next gamma cycle `edge_out` rises at `gamma_cnt`=5 and holds through 15, then 0 at the next `gamma_cnt`=0 (edge mode).
- **Back-pressure and bypass**:
  - Accept 2, hold `in_valid` with 9 → `in_ready` low until the boundary; 9 is accepted at `gamma_cnt`=0 and emitted one gamma cycle after 2.
  - Accept 7 at `gamma_cnt`=15 with empty holding → emitted at `gamma_cnt`=7 of the immediately following gamma cycle.
- **Null and extremes**: `in_null`=1 → no edge that cycle; value 0 → `edge_out` high from `gamma_cnt`=0; value 15 → high only at `gamma_cnt`=15.
- **Pulse mode** with `TE_PULSE_MODE_EN`, `PULSE_WIDTH`=8:
  - value 4 → high at `gamma_cnt` 4..11;
  - value 12 → high at 12..15 only.
- **Mid-cycle reset**: `grst` at `gamma_cnt`=6 with value 3 active and 10 held → `edge_out` 0 immediately; the next gamma cycle emits null; `in_ready`=1.
